// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART transmitter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Bit-timer width: enough bits to hold CLKS_PER_BIT-1.
  function automatic int timer_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with push/pop/full/empty/count.
// Latency: a pushed word is visible at pop_data the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_master.sv
// UART transmitter: buffers parallel words and serializes start/data/parity/stop.
// Latency: word accepted at edge N is popped at N+1, tx falls at N+2.
// Backpressure: in_ready drops while the input FIFO is full or reset is held.
module uart_tx_master
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic [CW-1:0]        fifo_count,
  output logic                 frame_done
);

  localparam int TW                 = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX    = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_DATA  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP  = 3'(STOP_BITS - 1);
  localparam bit HAS_PARITY         = (PARITY_EN != 0);
  localparam bit ODD                = (PARITY_ODD != 0);

  tx_state_e            state;
  logic [TW-1:0]        bit_timer;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 bit_end;
  logic                 last_stop;

  assign in_ready  = rst & ~fifo_full;
  assign bit_end   = (bit_timer == '0);
  assign last_stop = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
  // Pop from IDLE, or straight out of the final stop cycle for gapless frames.
  assign fifo_pop  = ~fifo_empty & ((state == IDLE) | last_stop);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid & in_ready),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Frame FSM with bit-timer, bit counter, shift/parity registers and registered line outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_timer  <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Outputs follow the current state one cycle later, keeping tx glitch-free.
      tx_busy    <= (state != IDLE);
      frame_done <= last_stop;
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        PARITY:  tx <= parity_bit;
        default: tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shift_reg  <= fifo_head;
            parity_bit <= (^fifo_head) ^ ODD;
            bit_timer  <= TMAX;
            bit_cnt    <= '0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_timer <= TMAX;
            bit_cnt   <= '0;
            state     <= DATA;
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_timer <= TMAX;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= HAS_PARITY ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            bit_timer <= TMAX;
            bit_cnt   <= '0;
            state     <= STOP;
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_timer <= TMAX;
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (!fifo_empty) begin
                shift_reg  <= fifo_head;
                parity_bit <= (^fifo_head) ^ ODD;
                state      <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_master.sv
// Self-checking bench: four transmitter configurations against a frame-timing reference model.
// Latency: n/a.
// Backpressure: stimulus holds each word until the model predicts acceptance.
module tb_uart_tx_master;

  localparam int CPB   = 4;
  localparam int NI    = 4;
  localparam int DEPTH = 4;
  localparam int MAXF  = 1024;

  // Per-instance frame formats: 8N1, 8E1, 8O1, 5N2.
  int db[NI] = '{8, 8, 8, 5};
  int pe[NI] = '{0, 1, 1, 0};
  int po[NI] = '{0, 0, 1, 0};
  int sb[NI] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       vld   [NI];
  logic [7:0] dat   [NI];
  logic       rdy   [NI];
  logic       txs   [NI];
  logic       busy  [NI];
  logic       done  [NI];
  logic [2:0] cnt_o [NI];

  always #5 clk = ~clk;

  uart_tx_master #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
    .tx(txs[0]), .tx_busy(busy[0]), .fifo_count(cnt_o[0]), .frame_done(done[0]));
  uart_tx_master #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]),
    .tx(txs[1]), .tx_busy(busy[1]), .fifo_count(cnt_o[1]), .frame_done(done[1]));
  uart_tx_master #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(rdy[2]), .in_data(dat[2]),
    .tx(txs[2]), .tx_busy(busy[2]), .fifo_count(cnt_o[2]), .frame_done(done[2]));
  uart_tx_master #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(rdy[3]), .in_data(dat[3][4:0]),
    .tx(txs[3]), .tx_busy(busy[3]), .fifo_count(cnt_o[3]), .frame_done(done[3]));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: each accepted word becomes a frame [start, start+len-1] on the line.
  int         m_cnt [NI];
  int         m_end [NI];
  int         fs    [NI][MAXF];
  logic [7:0] fw    [NI][MAXF];
  int         fn    [NI];
  int         fh    [NI];
  int         cyc;

  // Stimulus: a shared word list, each instance walks it at its own pace.
  logic [7:0] wl [256];
  int         wl_n;
  int         idx [NI];
  bit         gated;

  function automatic int frame_len(input int k);
    return CPB * (1 + db[k] + pe[k] + sb[k]);
  endfunction

  function automatic logic exp_bit(input int k, input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= db[k]) return w[b-1];
    if (pe[k] != 0 && b == db[k] + 1) return (^w) ^ (po[k] != 0);
    return 1'b1;
  endfunction

  task automatic load(input logic [7:0] a, input logic [7:0] b, input int n);
    // n words: a, a+b, a+2b ...
    for (int i = 0; i < n; i++) wl[i] = a + 8'(i) * b;
    wl_n = n;
    for (int k = 0; k < NI; k++) idx[k] = 0;
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      bit g;
      g = gated ? ($urandom_range(0, 3) != 0) : 1'b1;
      vld[k] = g && (idx[k] < wl_n);
      dat[k] = vld[k] ? wl[idx[k]] : 8'($urandom);
    end
    #1;
    for (int k = 0; k < NI; k++)
      check($sformatf("u%0d.in_ready@%0d", k, cyc + 1), 32'(rdy[k]),
            32'(rst && (m_cnt[k] < DEPTH)));
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!rst) begin
        m_cnt[k] = 0;
        m_end[k] = -100;
        fh[k]    = fn[k];
      end else begin
        bit acc;
        acc = vld[k] && (m_cnt[k] < DEPTH);
        for (int i = fh[k]; i < fn[k]; i++)
          if (fs[k][i] - 1 == cyc) m_cnt[k]--;
        if (acc && fn[k] < MAXF) begin
          int s;
          logic [7:0] msk;
          msk = 8'hFF >> (8 - db[k]);
          s = (cyc + 2 > m_end[k] + 1) ? cyc + 2 : m_end[k] + 1;
          fs[k][fn[k]] = s;
          fw[k][fn[k]] = dat[k] & msk;
          fn[k]++;
          m_end[k] = s + frame_len(k) - 1;
          m_cnt[k]++;
          idx[k]++;
        end
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      logic etx, eb, ed;
      int len;
      len = frame_len(k);
      etx = 1'b1; eb = 1'b0; ed = 1'b0;
      for (int i = fh[k]; i < fn[k]; i++) begin
        if (cyc >= fs[k][i] && cyc <= fs[k][i] + len - 1) begin
          etx = exp_bit(k, fw[k][i], (cyc - fs[k][i]) / CPB);
          eb  = 1'b1;
          ed  = (cyc == fs[k][i] + len - 1);
        end
      end
      check($sformatf("u%0d.tx@%0d", k, cyc), 32'(txs[k]), 32'(etx));
      check($sformatf("u%0d.tx_busy@%0d", k, cyc), 32'(busy[k]), 32'(eb));
      check($sformatf("u%0d.frame_done@%0d", k, cyc), 32'(done[k]), 32'(ed));
      check($sformatf("u%0d.fifo_count@%0d", k, cyc), 32'(cnt_o[k]), 32'(m_cnt[k]));
      while (fh[k] < fn[k] && fs[k][fh[k]] + len - 1 < cyc) fh[k]++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst   = 1'b0;
    gated = 1'b0;
    wl_n  = 0;
    cyc   = 0;
    for (int k = 0; k < NI; k++) begin
      vld[k] = 1'b0; dat[k] = 8'h00; idx[k] = 0;
      m_cnt[k] = 0; m_end[k] = -100; fn[k] = 0; fh[k] = 0;
    end

    // Words offered during reset must be dropped.
    load(8'h11, 8'h00, 1);
    run(3);
    rst = 1'b1;

    // Single frames: 0xA5 on all formats, then 0x07 for the parity cases, 0x1F for 5N2.
    load(8'hA5, 8'h00, 1); run(60);
    load(8'h07, 8'h00, 1); run(60);
    load(8'h1F, 8'h00, 1); run(60);

    // Back-pressure: 0x01..0x06 held valid until taken.
    load(8'h01, 8'h01, 6); run(320);

    // Back-to-back frames: 0x55 then 0xAA.
    load(8'h55, 8'h55, 2); run(120);

    // Reset in the middle of a frame, around data bit 3, then a clean frame.
    load(8'hF0, 8'h00, 1); run(19);
    rst = 1'b0; run(2);
    rst = 1'b1;
    load(8'h3C, 8'h00, 1); run(60);

    // Randomized traffic with valid gaps and occasional resets.
    for (int i = 0; i < 256; i++) wl[i] = 8'($urandom);
    wl_n = 256;
    for (int k = 0; k < NI; k++) idx[k] = 0;
    gated = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) != 0);
      step();
    end
    rst   = 1'b1;
    gated = 1'b0;
    wl_n  = 0;
    run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
